pc_sequencer: RTL

Program-counter sequencer for the 16-bit multicycle RISC core. It owns the PC register and a small return-address stack. It accepts one next-PC update request per instruction from the main control FSM, then forms the next PC from one of five sources: sequential, branch, jump, call or return. Jump and call targets are formed as the concatenation {PC+1[15:12], imm12}.

---
 rtl/pc_sequencer_pkg.sv | 22 ++
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/pc_sequencer_ras.sv | 50 +++++
 rtl/pc_sequencer.sv | 107 ++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the PC sequencer: update-kind encodings, fault bit
// positions, FSM state type and the fixed PC width.
package pc_seq_pkg;

  localparam int ADDR_W = 16;

  localparam logic [2:0] KIND_SEQ    = 3'd0;
  localparam logic [2:0] KIND_BRANCH = 3'd1;
  localparam logic [2:0] KIND_JUMP   = 3'd2;
  localparam logic [2:0] KIND_CALL   = 3'd3;
  localparam logic [2:0] KIND_RET    = 3'd4;

  localparam int FLT_OVERFLOW  = 0;
  localparam int FLT_UNDERFLOW = 1;
  localparam int FLT_ILLEGAL   = 2;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Update-request handshake between the core control FSM (master) and the
// PC sequencer (slave), plus the sequencer's status outputs.
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int RAS_DEPTH = 4
) ();
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic              upd_valid;
  logic              upd_ready;
  logic [2:0]        upd_kind;
  logic              br_taken;
  logic [ADDR_W-1:0] br_offset;
  logic [11:0]       imm12;
  logic [ADDR_W-1:0] pc_out;
  logic [CW-1:0]     ras_count;
  logic [2:0]        fault;

  modport master (
    output upd_valid, upd_kind, br_taken, br_offset, imm12,
    input  upd_ready, pc_out, ras_count, fault
  );

  modport slave (
    input  upd_valid, upd_kind, br_taken, br_offset, imm12,
    output upd_ready, pc_out, ras_count, fault
  );
endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack; a push onto a full stack overwrites the
// oldest entry so the most recent calls always remain reachable.
module return_addr_stack
  import pc_seq_pkg::*;
#(
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            push_data,
  output logic [ADDR_W-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]     sp_q;
  logic [PW-1:0]     top_idx;
  logic [CW-1:0]     cnt_q;

  // sp_q points at the next free slot; when full that slot holds the oldest entry.
  assign top_idx = sp_q - 1'b1;
  assign top     = mem_q[top_idx];
  assign count   = cnt_q;
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign empty   = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[sp_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (push) begin
      sp_q <= sp_q + 1'b1;
      if (!full) cnt_q <= cnt_q + 1'b1;
    end else if (pop && !empty) begin
      sp_q  <= sp_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, next-PC mux and two-state update FSM for the multicycle core;
// owns the return-address stack used by CALL/RET.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
  parameter int                RAS_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);
  seq_state_t        state_q;
  logic              ready_q;
  logic [ADDR_W-1:0] pc_q, pc_d, inc_q, off_q;
  logic [2:0]        kind_q, fault_q, fault_set;
  logic              taken_q;
  logic [11:0]       imm_q;

  logic                        push, pop;
  logic [ADDR_W-1:0]           ras_top;
  logic [$clog2(RAS_DEPTH):0]  ras_cnt;
  logic                        ras_full, ras_empty;

  return_addr_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (inc_q),
    .top       (ras_top),
    .count     (ras_cnt),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // Stack side effects only fire on the UPDATE edge, so a reset mid-update drops them.
  always_comb begin
    pc_d      = inc_q;
    fault_set = '0;
    push      = 1'b0;
    pop       = 1'b0;
    case (kind_q)
      KIND_SEQ:    pc_d = inc_q;
      KIND_BRANCH: pc_d = taken_q ? (pc_q + off_q) : inc_q;
      KIND_JUMP:   pc_d = {inc_q[15:12], imm_q};
      KIND_CALL: begin
        pc_d = {inc_q[15:12], imm_q};
        push = (state_q == S_UPDATE);
        fault_set[FLT_OVERFLOW] = ras_full;
      end
      KIND_RET: begin
        if (ras_empty) begin
          pc_d = inc_q;
          fault_set[FLT_UNDERFLOW] = 1'b1;
        end else begin
          pc_d = ras_top;
          pop  = (state_q == S_UPDATE);
        end
      end
      default: begin
        pc_d = inc_q;
        fault_set[FLT_ILLEGAL] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      pc_q    <= RESET_PC;
      inc_q   <= '0;
      fault_q <= '0;
      kind_q  <= KIND_SEQ;
      taken_q <= 1'b0;
      off_q   <= '0;
      imm_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.upd_valid) begin
            kind_q  <= bus.upd_kind;
            taken_q <= bus.br_taken;
            off_q   <= bus.br_offset;
            imm_q   <= bus.imm12;
            inc_q   <= pc_q + 1'b1;
            state_q <= S_UPDATE;
            ready_q <= 1'b0;
          end
        end
        default: begin
          pc_q    <= pc_d;
          fault_q <= fault_q | fault_set;
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.upd_ready = ready_q;
  assign bus.pc_out    = pc_q;
  assign bus.ras_count = ras_cnt;
  assign bus.fault     = fault_q;

endmodule
